uart_tx_fsm: RTL

//  Frame controller for the UART transmitter. Sequences the width-bit serializer.

---
 rtl/uart_tx_fsm_pkg.sv | 30 +++
 rtl/uart_tx_fsm_if.sv | 26 ++
 rtl/uart_tx_fsm_parity_calc.sv | 12 +
 rtl/uart_tx_fsm.sv | 108 ++++++++++
 4 files changed

// File: rtl/uart_tx_fsm_pkg.sv
// Shared definitions for the UART transmit frame controller:
// controller state encoding, line-mux select codes and the state-to-select decode.
package uart_tx_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        SEL_START  = 2'd0,
        SEL_DATA   = 2'd1,
        SEL_PARITY = 2'd2,
        SEL_STOP   = 2'd3
    } tx_sel_t;

    // Idle and any unused encoding share the stop select so the line rests high.
    function automatic tx_sel_t sel_for_state(tx_state_t s);
        case (s)
            ST_START:  return SEL_START;
            ST_DATA:   return SEL_DATA;
            ST_PARITY: return SEL_PARITY;
            default:   return SEL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Upstream handshake and serializer hookup of the UART transmit frame controller.
// master: the side feeding words and the serializer; slave: the frame controller.
interface uart_tx_fsm_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] Data;
    logic             Data_valid;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             Ser_done;
    logic             Ser_data;
    logic             Ser_EN;
    logic             valid_instop;
    logic             Busy;
    logic             TX_OUT;

    modport master (
        output Data, Data_valid, PAR_EN, PAR_TYP, Ser_done, Ser_data,
        input  Ser_EN, valid_instop, Busy, TX_OUT
    );

    modport slave (
        input  Data, Data_valid, PAR_EN, PAR_TYP, Ser_done, Ser_data,
        output Ser_EN, valid_instop, Busy, TX_OUT
    );
endinterface

// File: rtl/uart_tx_fsm_parity_calc.sv
// Combinational parity of a data word: even (typ=0) or odd (typ=1).
module uart_parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);

    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, LSB-first data, optional
// parity and 1..2 stop bits; accepts the next word in the final stop cycle
// so frames can run back to back.
module uart_tx_fsm
    import uart_tx_fsm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STOP_BITS = 1
) (
    input  logic          CLK,
    input  logic          Reset,
    uart_tx_fsm_if.slave  bus
);

    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

    tx_state_t state, state_nxt;
    tx_sel_t   sel;
    logic [1:0] stop_cnt;
    logic       last_stop;
    logic       accept;
    logic       vis;
    logic       ser_en;
    logic       par_calc;
    logic       par_bit_q;
    logic       par_en_q;

    uart_parity_calc #(.WIDTH(WIDTH)) u_parity (
        .data    (bus.Data),
        .par_typ (bus.PAR_TYP),
        .par_bit (par_calc)
    );

    assign last_stop = (stop_cnt == LAST_STOP);
    assign accept    = ((state == ST_IDLE) && bus.Data_valid) || vis;

    // State register; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Frame configuration captured only when a word is accepted.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else if (accept) begin
            par_bit_q <= par_calc;
            par_en_q  <= bus.PAR_EN;
        end
    end

    // Stop-bit counter: advances through the non-final stop cycles, zero elsewhere.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)                              stop_cnt <= '0;
        else if (state == ST_STOP && !last_stop) stop_cnt <= stop_cnt + 2'd1;
        else                                     stop_cnt <= '0;
    end

    // Next-state and serializer controls.
    always_comb begin
        state_nxt = state;
        ser_en    = 1'b0;
        vis       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.Data_valid) state_nxt = ST_START;
            end
            ST_START: begin
                ser_en    = 1'b1;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                ser_en = ~bus.Ser_done;
                if (bus.Ser_done) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (last_stop) begin
                    vis       = bus.Data_valid;
                    state_nxt = bus.Data_valid ? ST_START : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Line mux selected from the registered state.
    always_comb begin
        sel = sel_for_state(state);
        case (sel)
            SEL_START:  bus.TX_OUT = 1'b0;
            SEL_DATA:   bus.TX_OUT = bus.Ser_data;
            SEL_PARITY: bus.TX_OUT = par_bit_q;
            default:    bus.TX_OUT = 1'b1;
        endcase
    end

    assign bus.Ser_EN       = ser_en;
    assign bus.valid_instop = vis;
    assign bus.Busy         = (state != ST_IDLE);

endmodule
